// File: rtl/whack_input_capture_pkg.sv
// rtl/whack_input_capture_pkg.sv - shared FSM states and default sizing for the whack input capture block
package whack_input_capture_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ARMED  = 2'b01,
    LOCKED = 2'b10
  } whack_state_e;

  localparam int NUM_MOLES_DEF = 5;
  localparam int DB_CYCLES_SYN = 1000000;
  // Short window so simulations reach a stable level in a handful of cycles
  localparam int DB_CYCLES_SIM = 4;
  localparam int DB_CNT_W_DEF  = 20;
  localparam int SCORE_W_DEF   = 8;

endpackage

// File: rtl/whack_input_capture_switch_debouncer.sv
// rtl/whack_input_capture_switch_debouncer.sv - one-bit switch synchronizer, debouncer and press detector
module whack_input_capture_switch_debouncer
  import whack_input_capture_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_SYN,
  parameter int DB_CNT_W  = DB_CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic switch_in,
  output logic stable,
  output logic press
);

  logic                sync1;
  logic                sync2;
  logic                stable_d;
  logic [DB_CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1    <= switch_in;
      sync2    <= sync1;
      stable_d <= stable;
      // Any sample agreeing with the stable level restarts the window
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == DB_CNT_W'(DB_CYCLES - 1)) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = stable & ~stable_d;

endmodule

// File: rtl/whack_input_capture.sv
// rtl/whack_input_capture.sv - debounced mole switches scored as registered hit/miss pulses with saturating totals
module whack_input_capture
  import whack_input_capture_pkg::*;
#(
  parameter int NUM_MOLES = NUM_MOLES_DEF,
  parameter int DB_CYCLES = DB_CYCLES_SYN,
  parameter int DB_CNT_W  = DB_CNT_W_DEF,
  parameter int SCORE_W   = SCORE_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 game_active,
  input  logic [NUM_MOLES-1:0] mole_in,
  input  logic [NUM_MOLES-1:0] switch_in,
  output logic [NUM_MOLES-1:0] switch_db,
  output logic                 hit_pulse,
  output logic                 miss_pulse,
  output logic [SCORE_W-1:0]   hit_count,
  output logic [SCORE_W-1:0]   miss_count,
  output logic                 mole_ack
);

  logic [NUM_MOLES-1:0] press;
  logic [NUM_MOLES-1:0] mole_q;
  logic                 game_q;
  logic                 win_change;
  whack_state_e         state_q;
  whack_state_e         state_d;
  logic                 hit_d;
  logic                 miss_d;
  logic                 clear_d;
  logic                 ack_d;

  for (genvar i = 0; i < NUM_MOLES; i++) begin : g_db
    whack_input_capture_switch_debouncer #(
      .DB_CYCLES (DB_CYCLES),
      .DB_CNT_W  (DB_CNT_W)
    ) u_db (
      .clk       (clk),
      .reset     (reset),
      .switch_in (switch_in[i]),
      .stable    (switch_db[i]),
      .press     (press[i])
    );
  end

  assign win_change = (mole_in != mole_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    clear_d = 1'b0;
    ack_d   = win_change ? 1'b0 : mole_ack;
    if (!game_active) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!game_q) begin
            clear_d = 1'b1;
            ack_d   = 1'b0;
            state_d = ARMED;
          end
        end
        ARMED, LOCKED: begin
          // A window change re-arms in the same cycle, so a press then can still hit
          miss_d = |(press & ~mole_in);
          hit_d  = (|(press & mole_in)) && (state_q == ARMED || win_change);
          if (hit_d) begin
            ack_d   = 1'b1;
            state_d = LOCKED;
          end else if (win_change) begin
            state_d = ARMED;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      game_q     <= 1'b0;
      mole_q     <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      mole_ack   <= 1'b0;
    end else begin
      game_q     <= game_active;
      mole_q     <= mole_in;
      hit_pulse  <= hit_d;
      miss_pulse <= miss_d;
      mole_ack   <= ack_d;
      if (clear_d) begin
        hit_count  <= '0;
        miss_count <= '0;
      end else begin
        if (hit_d && hit_count != '1) begin
          hit_count <= hit_count + 1'b1;
        end
        if (miss_d && miss_count != '1) begin
          miss_count <= miss_count + 1'b1;
        end
      end
    end
  end

endmodule
